punch_sched: RTL
================

PUNCH_SCHED -- requirements
Module: punch_sched

Interface
REQ-001 SHALL have parameter W, default 8: operand and result width in bits, legal range 1..32.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 4 bits: per-requester request valid, bit i = requester i.
REQ-005 SHALL have port req_ready, output, 4 bits: per-requester accept; at most one bit high.
REQ-006 SHALL have port req_a, input, 4*W bits: operand A; requester i drives bits [i*W +: W].
REQ-007 SHALL have port req_b, input, 4*W bits: operand B, packed the same way as req_a.
REQ-008 SHALL have port resp_valid, output, 1 bit: result available.
REQ-009 SHALL have port resp_ready, input, 1 bit: downstream accepts the result.
REQ-010 SHALL have port resp_id, output, 2 bits: index of the requester that owns the result.
REQ-011 SHALL have port resp_data, output, W bits: the result.
REQ-012 SHALL have port busy, output, 1 bit: high when either pipeline stage holds a valid entry.

Function
REQ-013 SHALL share one compute unit among 4 requesters; the compute unit SHALL produce c = d1 ^ d2 ^ d3, where:
- d1 = (a + b) mod 2^W
- d2 = ~(a & b)
- d3 = (a + ~b) mod 2^W
- all terms are W bits wide; carries beyond W bits are discarded.
REQ-014 SHALL hold two pipeline stages:
- S1 registers a, b, id and a valid bit;
- S2 registers c, id and a valid bit;
- resp_valid, resp_id and resp_data SHALL be driven directly from S2.
REQ-015 S2 SHALL advance (load from S1, or clear when S1 is empty) when S2 is empty or resp_ready=1.
REQ-016 S1 SHALL advance when S1 is empty or S2 advances in the same cycle.
REQ-017 A handshake SHALL occur on requester i when req_valid[i]=1 and req_ready[i]=1 in the same cycle; the accepted a, b, i SHALL load into S1 on that edge.
REQ-018 req_ready SHALL be all-zero whenever S1 cannot advance (full pipeline under backpressure).
REQ-019 req_ready SHALL be combinational from req_valid, the RR pointer and the stall condition.
REQ-020 Arbitration SHALL be round-robin:
- priority order is ptr, ptr+1, ptr+2, ptr+3 (mod 4);
- the first valid requester in that order is granted.
REQ-021 The RR pointer SHALL update to (granted index + 1) mod 4 only on a handshake; with no handshake it SHALL hold.
REQ-022 Latency SHALL be exactly 2 cycles with no backpressure: a request accepted at edge t appears on resp_valid after edge t+1.
REQ-023 Throughput SHALL be one result per cycle when resp_ready=1 continuously.
REQ-024 While resp_valid=1 and resp_ready=0, resp_id and resp_data SHALL hold stable.
REQ-025 Result order SHALL equal acceptance order; no entry SHALL be dropped or duplicated.
REQ-026 A new acceptance SHALL be allowed in the same cycle as a response is taken when the pipeline is full (stall releases combinationally through resp_ready).
REQ-027 A requester deasserting req_valid before it is granted SHALL lose nothing: no request is recorded for it.

Reset
REQ-028 While reset_n=0, regardless of clk:
- S1 and S2 valid bits SHALL be 0;
- RR pointer SHALL be 0;
- resp_valid=0, resp_id=0, resp_data=0, busy=0;
- req_ready=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight entries; no response SHALL appear for them after release.
REQ-030 After reset_n rises, the first arbitration SHALL favour requester 0.

Verification
REQ-031 Directed scenarios the bench SHALL cover, W=8 (stimulus -> required response):
- Single request: requester 2 sends a=0x03, b=0x05, resp_ready=1 -> resp_valid two edges later, resp_id=2, resp_data=0x0B.
- Fairness: all four requesters held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; responses in the same order.
- Backpressure: resp_ready=0, requester 0 issues 3 requests -> only 2 accepted, then req_ready=0 and resp_data stable; resp_ready=1 -> third accepted that cycle, all three results arrive in order.
- Wrap/carry: a=0xFF, b=0x01 -> d1=0x00, d2=0xFE, d3=0xFD, resp_data=0x03.
- Reset mid-flight: reset_n low with both stages full -> resp_valid=0 immediately; after release the pipeline is empty and requester 0 is granted first.
- Sparse requests: only requester 3 valid, then only requester 1 -> pointer goes to 0, then requester 1 granted; no spurious req_ready on idle lanes.

Source files
------------

// File: rtl/punch_sched.sv
// Four-requester round-robin front end feeding one shared two-stage compute pipeline.
// Results leave in acceptance order through a valid/ready response port.
module punch_sched #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [3:0]     req_valid,
    output logic [3:0]     req_ready,
    input  logic [4*W-1:0] req_a,
    input  logic [4*W-1:0] req_b,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [1:0]     resp_id,
    output logic [W-1:0]   resp_data,
    output logic           busy
);

    // Shared compute unit; all terms wrap at W bits.
    function automatic logic [W-1:0] punch_calc(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        logic [W-1:0] d3;
        d1 = a + b;
        d2 = ~(a & b);
        d3 = a + ~b;
        return d1 ^ d2 ^ d3;
    endfunction

    logic           s1_valid_r;
    logic [W-1:0]   s1_a_r;
    logic [W-1:0]   s1_b_r;
    logic [1:0]     s1_id_r;
    logic           s2_valid_r;
    logic [W-1:0]   s2_c_r;
    logic [1:0]     s2_id_r;
    logic [1:0]     ptr_r;

    logic           s2_adv_s;
    logic           s1_adv_s;
    logic [3:0]     rot_s;
    logic [1:0]     off_s;
    logic           found_s;
    logic [1:0]     grant_idx_s;
    logic [3:0]     req_ready_s;
    logic           hs_s;
    logic [W-1:0]   acc_a_s;
    logic [W-1:0]   acc_b_s;

    // Stall chain: S2 drains on resp_ready, S1 moves whenever S2 makes room.
    always_comb begin
        s2_adv_s = ~s2_valid_r | resp_ready;
        s1_adv_s = ~s1_valid_r | s2_adv_s;
    end

    // Rotate requests so the pointer lane sits at bit 0, then pick the lowest set bit.
    always_comb begin
        rot_s = 4'b0000;
        case (ptr_r)
            2'd0:    rot_s = req_valid;
            2'd1:    rot_s = {req_valid[0],   req_valid[3:1]};
            2'd2:    rot_s = {req_valid[1:0], req_valid[3:2]};
            2'd3:    rot_s = {req_valid[2:0], req_valid[3]};
            default: rot_s = 4'b0000;
        endcase
    end

    // Priority encode the rotated vector into an offset from the pointer.
    always_comb begin
        off_s   = 2'd0;
        found_s = 1'b1;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: begin
                off_s   = 2'd0;
                found_s = 1'b0;
            end
        endcase
    end

    // Grant is one-hot and suppressed while stalled or held in reset.
    always_comb begin
        grant_idx_s = ptr_r + off_s;
        if (found_s && s1_adv_s && reset_n) begin
            req_ready_s = 4'b0001 << grant_idx_s;
        end else begin
            req_ready_s = 4'b0000;
        end
        hs_s    = |(req_ready_s & req_valid);
        acc_a_s = req_a[grant_idx_s*W +: W];
        acc_b_s = req_b[grant_idx_s*W +: W];
    end

    assign req_ready = req_ready_s;

    // Round-robin pointer moves past the winner only on an actual handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r <= 2'd0;
        end else if (hs_s) begin
            ptr_r <= grant_idx_s + 2'd1;
        end
    end

    // Stage 1 captures the accepted operands and owner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {W{1'b0}};
            s1_b_r     <= {W{1'b0}};
            s1_id_r    <= 2'd0;
        end else if (s1_adv_s) begin
            s1_valid_r <= hs_s;
            if (hs_s) begin
                s1_a_r  <= acc_a_s;
                s1_b_r  <= acc_b_s;
                s1_id_r <= grant_idx_s;
            end
        end
    end

    // Stage 2 holds the computed result; frozen while downstream backpressures.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_r <= 1'b0;
            s2_c_r     <= {W{1'b0}};
            s2_id_r    <= 2'd0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_c_r  <= punch_calc(s1_a_r, s1_b_r);
                s2_id_r <= s1_id_r;
            end
        end
    end

    assign resp_valid = s2_valid_r;
    assign resp_id    = s2_id_r;
    assign resp_data  = s2_c_r;
    assign busy       = s1_valid_r | s2_valid_r;

endmodule
